cdce_serial_shifter: RTL and testbench

Serial output stage that sits directly downstream of the CDCE command controller. It accepts one DATA_WIDTH-bit command per start_transaction pulse and shifts it MSB-first onto a 3-wire SPI-style bus (sclk, sdata, cs_n) to the CDCE device. It reports serial_ready back to the controller so the controller can pace the command ROM sequence.

---
 rtl/cdce_pkg.sv | 22 ++
 rtl/cdce_sclk_divider.sv | 37 +++
 rtl/cdce_serial_shifter.sv | 158 +++++++++++++++
 tb/tb_cdce_serial_shifter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdce_pkg.sv
// Shared CDCE definitions: frame constants used by the command controller, command ROM
// and serial shifter, plus the serial shifter's state encoding.
package cdce_pkg;

    localparam int CDCE_DATA_WIDTH = 20;
    localparam int CDCE_CLK_DIV    = 4;
    localparam int CDCE_CS_GAP     = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_HOLD     = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

    // Cycles serial_ready stays low for one frame.
    function automatic int frame_busy_cycles(input int dw, input int cd, input int gap);
        return 2 * cd * dw + cd + gap;
    endfunction

endpackage

// File: rtl/cdce_sclk_divider.sv
// Half-period tick generator for the CDCE serial clock; a synchronous clear restarts the
// phase so every frame starts with a full low half-period.
module cdce_sclk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);

    localparam int             CW   = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0]  TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clear_i || (cnt_q == TERM)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/cdce_serial_shifter.sv
// Serial output stage: shifts one command word MSB-first onto the CDCE 3-wire bus
// (sclk / sdata / cs_n) per accepted start, and paces the controller via serial_ready.
module cdce_serial_shifter
    import cdce_pkg::*;
#(
    parameter int DATA_WIDTH = CDCE_DATA_WIDTH,
    parameter int CLK_DIV    = CDCE_CLK_DIV,
    parameter int CS_GAP     = CDCE_CS_GAP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_transaction,
    input  logic [DATA_WIDTH-1:0] command,
    output logic                  serial_ready,
    output logic                  sclk,
    output logic                  sdata,
    output logic                  cs_n,
    output logic                  transaction_done
);

    localparam int                BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int                GAP_W    = $clog2(CS_GAP) + 1;
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0]  GAP_TERM = GAP_W'(CS_GAP - 1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic                    ready_q, ready_d;
    logic                    sclk_q, sclk_d;
    logic                    sdata_q, sdata_d;
    logic                    cs_n_q, cs_n_d;
    logic                    done_q, done_d;
    logic                    div_clear;
    logic                    div_tick;

    // Divider is held cleared while idle so the first low half-period is always full length.
    assign div_clear = (state_q == ST_IDLE);

    cdce_sclk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .clear_i (div_clear),
        .tick_o  (div_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start_transaction) state_d = ST_SHIFT_LO;
            ST_SHIFT_LO: if (div_tick) state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: if (div_tick) state_d = (bit_cnt_q != '0) ? ST_SHIFT_LO : ST_HOLD;
            ST_HOLD:     if (div_tick) state_d = ST_GAP;
            ST_GAP:      if (gap_cnt_q == GAP_TERM) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every target gets a hold or default value first, so no branch infers a latch.
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = '0;
        ready_d   = ready_q;
        sclk_d    = sclk_q;
        sdata_d   = sdata_q;
        cs_n_d    = cs_n_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_transaction) begin
                    shift_d   = command;
                    bit_cnt_d = BIT_LAST;
                    ready_d   = 1'b0;
                    cs_n_d    = 1'b0;
                    sclk_d    = 1'b0;
                    sdata_d   = command[DATA_WIDTH-1];
                end
            end
            ST_SHIFT_LO: begin
                if (div_tick) sclk_d = 1'b1;
            end
            ST_SHIFT_HI: begin
                // Next bit goes out together with the sclk falling edge.
                if (div_tick) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q != '0) begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        shift_d   = shift_q << 1;
                        sdata_d   = shift_q[DATA_WIDTH-2];
                    end
                end
            end
            ST_HOLD: begin
                if (div_tick) begin
                    cs_n_d  = 1'b1;
                    sdata_d = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_TERM) begin
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                ready_d = 1'b1;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                sdata_d = 1'b0;
            end
        endcase
    end

    // NOTE: the shift register is a handful of flops, not a memory, so it is reset with the
    // rest of the datapath; an aborted frame leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ready_q   <= 1'b1;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ready_q   <= ready_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            cs_n_q    <= cs_n_d;
            done_q    <= done_d;
        end
    end

    assign serial_ready     = ready_q;
    assign sclk             = sclk_q;
    assign sdata            = sdata_q;
    assign cs_n             = cs_n_q;
    assign transaction_done = done_q;

endmodule

// File: tb/tb_cdce_serial_shifter.sv
// Bench for cdce_serial_shifter: a default instance plus a CLK_DIV=1/CS_GAP=1 instance,
// each watched by a bus-level reference monitor that reconstructs frames from the pins.
module tb_cdce_serial_shifter;

    localparam int DW  = 20;
    localparam int CD0 = 4;
    localparam int G0  = 4;
    localparam int CD1 = 1;
    localparam int G1  = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start0, start1;
    logic [DW-1:0] cmd0, cmd1;
    logic          rdy0, sclk0, sd0, cs0, dn0;
    logic          rdy1, sclk1, sd1, cs1, dn1;

    always #5 clk = ~clk;

    cdce_serial_shifter #(.DATA_WIDTH(DW), .CLK_DIV(CD0), .CS_GAP(G0)) dut0 (
        .clk(clk), .reset(reset), .start_transaction(start0), .command(cmd0),
        .serial_ready(rdy0), .sclk(sclk0), .sdata(sd0), .cs_n(cs0), .transaction_done(dn0)
    );

    cdce_serial_shifter #(.DATA_WIDTH(DW), .CLK_DIV(CD1), .CS_GAP(G1)) dut1 (
        .clk(clk), .reset(reset), .start_transaction(start1), .command(cmd1),
        .serial_ready(rdy1), .sclk(sclk1), .sdata(sd1), .cs_n(cs1), .transaction_done(dn1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference monitor state, one slot per instance.
    logic          p_rdy[2], p_cs[2], p_sc[2], p_sd[2];
    logic          in_frame[2], acc_pend[2];
    logic [DW-1:0] exp_word[2], word[2];
    int            rises[2], cs_low[2], rdy_low[2];
    int            cyc[2], last_done_cyc[2], start_gap[2];
    int            accepts[2], frames[2];

    task automatic mon_step(input int k, input logic rst, input logic rdy, input logic cs,
                            input logic sc, input logic sd, input logic dn, input logic st,
                            input logic [DW-1:0] cm);
        int   cd, gp;
        logic rdy_rise, cs_rise;
        string u;
        u  = $sformatf("u%0d_", k);
        cd = (k == 0) ? CD0 : CD1;
        gp = (k == 0) ? G0 : G1;
        cyc[k]++;
        if (rst) begin
            in_frame[k]      = 1'b0;
            acc_pend[k]      = 1'b0;
            last_done_cyc[k] = -1000;
        end else begin
            rdy_rise = rdy && !p_rdy[k];
            cs_rise  = cs && !p_cs[k];
            if (acc_pend[k]) begin
                check({u, "ready_falls_after_accept"}, rdy, 1'b0);
                check({u, "cs_n_falls_after_accept"}, cs, 1'b0);
                check({u, "first_bit_is_msb"}, sd, exp_word[k][DW-1]);
                start_gap[k] = cyc[k] - last_done_cyc[k];
            end
            if (!in_frame[k])
                check({u, "idle_outputs"}, {rdy, cs, sc, sd}, 4'b1100);
            if ((sd !== p_sd[k]) && !acc_pend[k])
                check({u, "sdata_moves_only_on_sclk_fall"}, (p_sc[k] && !sc) || cs_rise, 1'b1);
            if (in_frame[k]) begin
                if (sc && !p_sc[k]) begin
                    rises[k]++;
                    word[k] = {word[k][DW-2:0], sd};
                    check({u, "cs_n_low_at_sclk_rise"}, cs, 1'b0);
                end
                if (!cs)  cs_low[k]++;
                if (!rdy) rdy_low[k]++;
                if (cs_rise) begin
                    check({u, "frame_bits"}, word[k], exp_word[k]);
                    check({u, "sclk_rise_count"}, rises[k], DW);
                    check({u, "cs_n_low_cycles"}, cs_low[k], 2 * cd * DW + cd);
                    frames[k]++;
                end
                if (rdy_rise) begin
                    check({u, "ready_low_cycles"}, rdy_low[k], 2 * cd * DW + cd + gp);
                    check({u, "done_with_ready"}, dn, 1'b1);
                    in_frame[k]      = 1'b0;
                    last_done_cyc[k] = cyc[k];
                end
            end
            if (dn) check({u, "done_only_at_ready_rise"}, rdy_rise, 1'b1);
            acc_pend[k] = rdy && st;
            if (acc_pend[k]) begin
                exp_word[k] = cm;
                word[k]     = '0;
                rises[k]    = 0;
                cs_low[k]   = 0;
                rdy_low[k]  = 0;
                accepts[k]++;
                in_frame[k] = 1'b1;
            end
        end
        p_rdy[k] = rdy;
        p_cs[k]  = cs;
        p_sc[k]  = sc;
        p_sd[k]  = sd;
    endtask

    always @(negedge clk) mon_step(0, reset, rdy0, cs0, sclk0, sd0, dn0, start0, cmd0);
    always @(negedge clk) mon_step(1, reset, rdy1, cs1, sclk1, sd1, dn1, start1, cmd1);

    task automatic send0(input logic [DW-1:0] c);
        @(posedge clk); #2;
        start0 = 1'b1;
        cmd0   = c;
        @(posedge clk); #2;
        start0 = 1'b0;
        cmd0   = $urandom;
    endtask

    task automatic wait_idle(input int k, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!in_frame[k]) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1'b1);
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n_sent0;
        logic          ok;
        logic [DW-1:0] c;
        logic [DW-1:0] rom[3];

        n_sent0 = 0;
        for (int k = 0; k < 2; k++) begin
            accepts[k] = 0;
            frames[k]  = 0;
            cyc[k]     = 0;
        end
        start0 = 1'b0; start1 = 1'b0; cmd0 = '0; cmd1 = '0;
        reset  = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Idle after reset with no start.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_after_reset", {rdy0, cs0, sclk0, sd0, dn0}, 5'b11000);
        end

        // Directed frame.
        send0(20'hA5C3F);
        n_sent0++;
        wait_idle(0, "u0_a5c3f_completes");

        // Start held high across two frames; the second must follow done with no gap.
        @(posedge clk); #2;
        start0 = 1'b1;
        cmd0   = 20'h00001;
        ok     = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #2;
            if (accepts[0] == n_sent0 + 1) cmd0 = 20'hFFFFE;
            if (accepts[0] == n_sent0 + 2) begin
                start0 = 1'b0;
                ok     = 1'b1;
                break;
            end
        end
        check("u0_two_frames_accepted", ok, 1'b1);
        n_sent0 += 2;
        wait_idle(0, "u0_back_to_back_completes");
        check("u0_back_to_back_gap", start_gap[0], 1);

        // Random frames with spurious starts mid-frame.
        for (int f = 0; f < 6; f++) begin
            c = $urandom;
            send0(c);
            n_sent0++;
            repeat ($urandom_range(5, 120)) @(posedge clk);
            #2;
            start0 = 1'b1;
            cmd0   = ~c;
            @(posedge clk); #2;
            start0 = 1'b0;
            wait_idle(0, "u0_random_frame_completes");
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        check("u0_no_extra_accepts", accepts[0], n_sent0);

        // Reset at the 10th sclk rise aborts the frame asynchronously.
        send0($urandom);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rises[0] == 10) begin
                ok = 1'b1;
                break;
            end
        end
        check("u0_reached_10th_rise", ok, 1'b1);
        check("u0_in_frame_before_reset", {cs0, sclk0}, 2'b01);
        #1 reset = 1'b1;
        #1 check("u0_async_reset_outputs", {rdy0, cs0, sclk0, sd0, dn0}, 5'b11000);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (4) @(posedge clk);
        send0(20'h12345);
        n_sent0++;
        wait_idle(0, "u0_after_reset_completes");
        check("u0_frames_completed", frames[0], n_sent0);
        check("u0_accepts_incl_aborted", accepts[0], n_sent0 + 1);

        // Fast instance paced by a trigger/delay/increment/wait controller over a 3-entry ROM.
        for (int i = 0; i < 3; i++) rom[i] = $urandom;
        for (int a = 0; a < 3; a++) begin
            ok = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (rdy1) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("u1_ready_for_trigger", ok, 1'b1);
            @(posedge clk); #2;
            start1 = 1'b1;
            cmd1   = rom[a];
            @(posedge clk); #2;
            start1 = 1'b0;
            @(negedge clk);
            check("u1_wait_sees_busy", rdy1, 1'b0);
        end
        wait_idle(1, "u1_sequence_completes");
        check("u1_frames_completed", frames[1], 3);
        check("u1_accepts", accepts[1], 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
